// File: rtl/seq_match_fsm_pkg.sv
// Shared types and constants for the sequence-identifier match logic.
package seqid_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    // Width needed to count 0..n window bits.
    function automatic int fill_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_match_fsm_sat_counter.sv
// Saturating event counter with a sticky saturation flag; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == CNT_MAX) begin
            return value;
        end
        return value + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] count_nxt;

    assign count_nxt = sat_inc(count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc) begin
            count <= count_nxt;
            if (count_nxt == CNT_MAX) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_match_fsm.sv
// Compares the shift-register window against a programmable pattern, tracking
// window fill and emitting a registered match pulse plus a saturating count.
module seq_match_fsm
    import seqid_pkg::*;
#(
    parameter int                         SEQUENCE_SIZE = 4,
    parameter int                         CNT_W         = 8,
    parameter logic [SEQUENCE_SIZE-1:0]   PATTERN_RST   = DEFAULT_PATTERN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEQUENCE_SIZE-1:0] p_in,
    input  logic [SEQUENCE_SIZE-1:0] pattern,
    input  logic                     pattern_ld,
    input  logic                     overlap,
    input  logic                     count_clr,
    output logic                     match,
    output logic                     window_valid,
    output logic [CNT_W-1:0]         match_count,
    output logic                     sat
);

    localparam int                FILL_W    = fill_w(SEQUENCE_SIZE);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQUENCE_SIZE);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    state_t                     state, state_nxt;
    logic [FILL_W-1:0]          fill, fill_nxt;
    logic [SEQUENCE_SIZE-1:0]   pattern_q;
    logic                       hit_p0;
    logic                       match_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            fill      <= '0;
            pattern_q <= PATTERN_RST;
            match_p1  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fill     <= fill_nxt;
            match_p1 <= hit_p0;
            if (pattern_ld) begin
                pattern_q <= pattern;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        hit_p0    = 1'b0;
        case (state)
            FILL: begin
                fill_nxt = fill + FILL_ONE;
                if (fill_nxt == FILL_FULL) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                hit_p0 = (p_in == pattern_q);
                // Non-overlapping restart: the bit entering at this edge is the
                // first bit of the next window, so fill resumes at one.
                if (hit_p0 && !overlap) begin
                    fill_nxt  = FILL_ONE;
                    state_nxt = (FILL_ONE == FILL_FULL) ? ARMED : FILL;
                end
            end
            default: begin
                state_nxt = FILL;
                fill_nxt  = '0;
            end
        endcase
    end

    // ---- stage p1: registered match pulse and counter ----
    assign match        = match_p1;
    assign window_valid = (state == ARMED);

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_sat_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (hit_p0),
        .clr  (count_clr),
        .count(match_count),
        .sat  (sat)
    );

endmodule

// File: tb/tb_seq_match_fsm.sv
// Directed bench for seq_match_fsm: models the upstream shift register and
// compares against hand-computed per-cycle expectations.
module tb_seq_match_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] p_in = 4'b0000;
    logic [3:0] pattern = 4'b0000;
    logic       pattern_ld = 1'b0;
    logic       overlap = 1'b0;
    logic       count_clr = 1'b0;

    logic       match, window_valid, sat;
    logic [7:0] match_count;
    logic       match2, window_valid2, sat2;
    logic [1:0] match_count2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_match_fsm u_dut (
        .clk         (clk),
        .rst         (rst),
        .p_in        (p_in),
        .pattern     (pattern),
        .pattern_ld  (pattern_ld),
        .overlap     (overlap),
        .count_clr   (count_clr),
        .match       (match),
        .window_valid(window_valid),
        .match_count (match_count),
        .sat         (sat)
    );

    seq_match_fsm #(
        .SEQUENCE_SIZE(4),
        .CNT_W        (2),
        .PATTERN_RST  (4'b1111)
    ) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .p_in        (p_in),
        .pattern     (pattern),
        .pattern_ld  (pattern_ld),
        .overlap     (overlap),
        .count_clr   (count_clr),
        .match       (match2),
        .window_valid(window_valid2),
        .match_count (match_count2),
        .sat         (sat2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: upstream register shifts b in as the newest bit; one-shot controls drop.
    task automatic cyc(input logic b);
        @(posedge clk);
        #1;
        p_in       = {p_in[2:0], b};
        pattern_ld = 1'b0;
        count_clr  = 1'b0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pattern_ld = 1'b0;
        count_clr  = 1'b0;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        p_in = 4'b0000;
    endtask

    initial begin
        logic [4:0] s1;
        logic [7:0] s2;
        logic [8:0] s3;
        logic [8:0] s5;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst match", match, 1'b0);
        check("rst window_valid", window_valid, 1'b0);
        check("rst count", match_count, 8'd0);
        check("rst sat", sat, 1'b0);

        // Test 1: first window and single match, one-cycle pulse
        do_reset();
        overlap = 1'b1;
        s1 = 5'b10110;
        for (int k = 1; k <= 5; k++) begin
            cyc(s1[5-k]);
            check($sformatf("t1 wv c%0d", k), window_valid, (k >= 4));
            check($sformatf("t1 match c%0d", k), match, (k == 5));
        end
        check("t1 count", match_count, 8'd1);
        cyc(1'b1);
        check("t1 match c6", match, 1'b0);

        // Test 2: overlapping detection
        do_reset();
        overlap = 1'b1;
        s2 = 8'b10110110;
        for (int k = 1; k <= 8; k++) begin
            cyc(s2[8-k]);
            check($sformatf("t2 match c%0d", k), match, (k == 5 || k == 8));
        end
        check("t2 count", match_count, 8'd2);

        // Test 3a: non-overlapping, same stream gives one match
        do_reset();
        overlap = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc(s2[8-k]);
            check($sformatf("t3a match c%0d", k), match, (k == 5));
        end
        check("t3a count", match_count, 8'd1);

        // Test 3b: non-overlapping restart refills before re-arming
        do_reset();
        overlap = 1'b0;
        s3 = 9'b101110110;
        for (int k = 1; k <= 9; k++) begin
            cyc(s3[9-k]);
            check($sformatf("t3b wv c%0d", k), window_valid, (k == 4 || k == 8));
            check($sformatf("t3b match c%0d", k), match, (k == 5 || k == 9));
        end
        check("t3b count", match_count, 8'd2);

        // Test 4: 2-bit counter saturation, then clear colliding with a hit
        do_reset();
        overlap = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b1);
            check($sformatf("t4 match2 c%0d", k), match2, (k >= 5));
            check($sformatf("t4 count2 c%0d", k), match_count2,
                  (k < 5) ? 0 : ((k - 4 > 3) ? 3 : k - 4));
            check($sformatf("t4 sat2 c%0d", k), sat2, (k >= 7));
        end
        check("t4 main count", match_count, 8'd0);
        count_clr = 1'b1;
        cyc(1'b1);
        check("t4 clr count2", match_count2, 2'd0);
        check("t4 clr sat2", sat2, 1'b0);
        check("t4 clr match2", match2, 1'b1);
        cyc(1'b1);
        check("t4 post clr count2", match_count2, 2'd1);
        check("t4 post clr sat2", sat2, 1'b0);

        // Test 5: pattern load uses old pattern in the load cycle
        do_reset();
        overlap = 1'b1;
        s5 = 9'b101101101;
        for (int k = 1; k <= 9; k++) begin
            cyc(s5[9-k]);
            check($sformatf("t5 match c%0d", k), match, (k == 5 || k == 6 || k == 9));
            if (k == 4) begin
                pattern    = 4'b0110;
                pattern_ld = 1'b1;
            end
        end
        check("t5 count", match_count, 8'd3);

        // Test 6: reset right after a hit drops the pending pulse
        do_reset();
        overlap = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            cyc(s1[5-k]);
        end
        check("t6 pre-rst match", match, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        check("t6 rst match", match, 1'b0);
        check("t6 rst count", match_count, 8'd0);
        check("t6 rst wv", window_valid, 1'b0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        p_in = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1);
            check($sformatf("t6 wv c%0d", k), window_valid, (k == 4));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_match_fsm.md
Name: seq_match_fsm

Overview:
Downstream consumer of the serial-to-parallel shift register in the sequence-identifier design. Every clock it compares the shift register's parallel window against a programmable target pattern. It tracks window fill after reset or restart, and supports overlapping and non-overlapping detection. It emits a registered one-cycle match pulse and keeps a saturating match counter.

Parameters:
SEQUENCE_SIZE, 4, window/pattern width N; must equal the upstream shift register's size.
CNT_W, 8, match counter width.
PATTERN_RST, 4'b1011, value loaded into the pattern register on reset (SEQUENCE_SIZE bits).

Ports:
clk  input  1  single clock, rising edge; same clock as the shift register.
rst  input  1  asynchronous, active-high reset.
p_in  input  SEQUENCE_SIZE  parallel window from the shift register; p_in[0] is the newest bit, p_in[N-1] the oldest.
pattern  input  SEQUENCE_SIZE  new target pattern, bit order as p_in.
pattern_ld  input  1  sample pattern into pattern_q at this edge.
overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
count_clr  input  1  synchronous clear of match_count and sat.
match  output  1  one-cycle pulse, registered.
window_valid  output  1  high when the window holds N bits shifted since reset or restart.
match_count  output  CNT_W  number of matches, saturating.
sat  output  1  sticky; set when match_count reaches its all-ones value.

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: match=0, window_valid=0, match_count=0, sat=0, pattern_q=PATTERN_RST, fill=0, state=FILL.
- The upstream register shifts on every clk edge and has no reset, so p_in is undefined until N edges have occurred.
- fill counter (width clog2(N+1)) increments by 1 per edge while fill<N and saturates at N.
- FSM states:
  - FILL: fill<N. Transition to ARMED when fill reaches N.
  - ARMED: window_valid=1. Transition to FILL only through a non-overlapping restart.
- window_valid is a combinational decode of state==ARMED. It is 1 in the cycle where p_in holds N defined bits, i.e. cycle N after reset release.
- hit = ARMED and (p_in == pattern_q), evaluated combinationally in cycle t.
- match is registered from hit: it is high in cycle t+1 for exactly one cycle. Latency is one clock from window to pulse.
- On hit with overlap=1: fill and state are unchanged; the next match is possible in cycle t+1.
- On hit with overlap=0: fill:=1 and state:=FILL. The bit shifted at this edge is counted, so ARMED returns in cycle t+N. Windows containing any bit of the matched sequence are never matched.
- match_count increments on hit and saturates at 2^CNT_W-1. sat sets when the increment reaches the maximum and stays set.
- count_clr is synchronous. It has priority over a same-cycle increment: result is count=0, sat=0. The match pulse is still produced.
- pattern_ld writes pattern_q at the edge. A compare in the same cycle uses the old pattern_q. The load does not affect fill or state.
- rst asserted mid-operation: all state returns to reset values immediately. A pending match pulse is dropped. Fill restarts from 0 after release.
- overlap changes take effect from the next hit evaluation. No retroactive effect.

Decomposition:
- Package seqid_pkg holds:
  - state_t enum {FILL, ARMED};
  - constant DEFAULT_PATTERN;
  - function fill_w(N) = clog2(N+1).
- One natural sub-module: sat_counter (CNT_W; inputs inc and clr, clr priority; outputs count and sticky sat). It is instantiated once.
- Top-level integration wires the shift register's p_out to p_in. That wiring is outside this block.

Test Plan:
1. Reset, then bits 1,0,1,1 shifted (N=4, pattern 1011) → window_valid first high in cycle 4 with p_in=4'b1011; match high in cycle 5 only; match_count=1.
2. overlap=1, stream 1,0,1,1,0,1,1 → matches after bits 4 and 7; match_count=2.
3. overlap=0, same stream → single match after bit 4. Stream 1,0,1,1,1,0,1,1 → second match after bit 8; window_valid low for cycles 5–7.
4. CNT_W=2, five overlapping matches → count goes 1,2,3,3,3 and sat sets on the third match. count_clr asserted together with a hit → count=0, sat=0, match still pulses.
5. pattern_ld with pattern=4'b0110 in the cycle p_in=1011 → that cycle still matches 1011. Later p_in=0110 matches; 1011 no longer matches.
6. rst asserted the cycle after a hit → match forced to 0 asynchronously, count=0. window_valid stays low for 4 cycles after release.
